// File: rtl/manual_drive_ctrl.sv
// manual_drive_ctrl
//   Manual-mode driving controller sitting directly upstream of the simulator
//   signals. It owns the power state (press to power on, long hold to power
//   off), runs the NOT_STARTING/STARTING/MOVING machine from the pedal and
//   gear levels, and produces the move/turn commands, the blinking turn lamps
//   and a saturating mileage count.
//
// Ports
//   clk, rst             100 MHz clock, asynchronous active-low reset
//   power_btn            debounced power button (1 = pressed)
//   mode_sel[1:0]        2'b01 enables manual driving, anything else idles it
//   throttle, clutch,
//   brake, reverse_sw    debounced pedal / gear levels (reverse_sw 1 = reverse)
//   turn_left/right      debounced turn requests
//   power_on             registered power state
//   drive_state[1:0]     00 NOT_STARTING, 01 STARTING, 10 MOVING
//   move_*_signal        forward / backward command to the simulator
//   turn_*_signal        left / right command to the simulator
//   turn_*_light         blinking lamps, on-phase first
//   mileage[MILE_W-1:0]  distance count, cleared at power-on, saturating
//
// All inputs go through a 2-flop synchroniser; every output is a flop fed
// from the next-state logic, so a synchronised input change is visible on the
// outputs one edge after it is first seen.

module turn_blinker #(
    parameter int HALF_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,    // next-cycle value of the turn signal
    output logic lamp
);
    localparam int PERIOD = 2 * HALF_CYCLES;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic          req_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        cnt_inc = (cnt == CW'(PERIOD - 1)) ? '0 : cnt + 1'b1;
    end

    // cnt is the phase of the lamp inside one on/off period; a fresh request
    // restarts it so the lamp always begins with a full on-phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= 1'b0;
            cnt   <= '0;
            lamp  <= 1'b0;
        end else begin
            req_q <= req;
            if (!req) begin
                cnt  <= '0;
                lamp <= 1'b0;
            end else if (!req_q) begin
                cnt  <= '0;
                lamp <= 1'b1;
            end else begin
                cnt  <= cnt_inc;
                lamp <= (cnt_inc < CW'(HALF_CYCLES));
            end
        end
    end
endmodule

module manual_drive_ctrl #(
    parameter int LONG_PRESS_CYCLES = 100_000_000,
    parameter int BLINK_HALF_CYCLES = 50_000_000,
    parameter int MILE_TICK_CYCLES  = 10_000_000,
    parameter int MILE_W            = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power_btn,
    input  logic [1:0]        mode_sel,
    input  logic              throttle,
    input  logic              clutch,
    input  logic              brake,
    input  logic              reverse_sw,
    input  logic              turn_left,
    input  logic              turn_right,
    output logic              power_on,
    output logic [1:0]        drive_state,
    output logic              move_forward_signal,
    output logic              move_backward_signal,
    output logic              turn_left_signal,
    output logic              turn_right_signal,
    output logic              turn_left_light,
    output logic              turn_right_light,
    output logic [MILE_W-1:0] mileage
);
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_MOVE  = 2'b10;

    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int TICK_W = (MILE_TICK_CYCLES > 1) ? $clog2(MILE_TICK_CYCLES) : 1;

    // ---------------- input synchroniser ----------------
    logic [9:0] raw, sync1, sync2;
    assign raw = {power_btn, mode_sel, throttle, clutch, brake,
                  reverse_sw, turn_left, turn_right};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    logic       btn, thr, clu, brk, rev, tl, tr;
    logic [1:0] mode;
    assign {btn, mode, thr, clu, brk, rev, tl, tr} = sync2;

    // ---------------- edge detect / hold counter ----------------
    logic              btn_q, rev_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              btn_rise, rev_tog, long_press;

    assign btn_rise   = btn & ~btn_q;
    assign rev_tog    = rev ^ rev_q;
    // hold_cnt counts earlier consecutive high cycles, so this fires on the
    // LONG_PRESS_CYCLES-th one; it saturates so a continued hold fires once.
    assign long_press = btn && (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q    <= 1'b0;
            rev_q    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            btn_q <= btn;
            rev_q <= rev;
            if (!btn)
                hold_cnt <= '0;
            else if (hold_cnt != HOLD_W'(LONG_PRESS_CYCLES))
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // ---------------- power / drive FSM ----------------
    logic [1:0] state, st_nxt;
    logic       pwr_nxt, fsm_en;

    assign fsm_en = power_on && (mode == 2'b01);

    always_comb begin
        pwr_nxt = power_on;
        st_nxt  = state;
        if (power_on) begin
            if (long_press) begin
                pwr_nxt = 1'b0;
            end else if (fsm_en) begin
                case (state)
                    ST_IDLE: begin
                        if (thr && !clu)              pwr_nxt = 1'b0;   // stall
                        else if (thr && clu && !brk)  st_nxt  = ST_START;
                    end
                    ST_START: begin
                        if (brk)                      st_nxt  = ST_IDLE;
                        else if (thr && !clu)         st_nxt  = ST_MOVE;
                    end
                    ST_MOVE: begin
                        if (brk)                      st_nxt  = ST_IDLE;
                        else if (rev_tog && !clu)     pwr_nxt = 1'b0;   // gear crash
                        else if (clu || !thr)         st_nxt  = ST_START;
                    end
                    default:                          st_nxt  = ST_IDLE;
                endcase
            end
        end else if (btn_rise) begin
            pwr_nxt = 1'b1;
        end
        // Off, just powering up, or not in manual mode: parked.
        if (!pwr_nxt || !fsm_en)
            st_nxt = ST_IDLE;
    end

    // Output commands are derived from the next state so they land on the
    // same edge as drive_state; st_nxt is already idle whenever power drops.
    logic       mf_nxt, mb_nxt, turn_ok;
    logic [1:0] turn_req, turn_lamp;

    assign mf_nxt      = (st_nxt == ST_MOVE) && !rev;
    assign mb_nxt      = (st_nxt == ST_MOVE) &&  rev;
    assign turn_ok     = (st_nxt != ST_IDLE);
    assign turn_req[0] = turn_ok && tl && !tr;
    assign turn_req[1] = turn_ok && tr && !tl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            power_on             <= 1'b0;
            state                <= ST_IDLE;
            move_forward_signal  <= 1'b0;
            move_backward_signal <= 1'b0;
            turn_left_signal     <= 1'b0;
            turn_right_signal    <= 1'b0;
        end else begin
            power_on             <= pwr_nxt;
            state                <= st_nxt;
            move_forward_signal  <= mf_nxt;
            move_backward_signal <= mb_nxt;
            turn_left_signal     <= turn_req[0];
            turn_right_signal    <= turn_req[1];
        end
    end

    assign drive_state = state;

    // ---------------- turn lamps (lane 0 = left, lane 1 = right) ----------------
    for (genvar i = 0; i < 2; i++) begin : g_blink
        turn_blinker #(.HALF_CYCLES(BLINK_HALF_CYCLES)) u_blink (
            .clk  (clk),
            .rst  (rst),
            .req  (turn_req[i]),
            .lamp (turn_lamp[i])
        );
    end

    assign turn_left_light  = turn_lamp[0];
    assign turn_right_light = turn_lamp[1];

    // ---------------- mileage ----------------
    logic [TICK_W-1:0] tick_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            mileage  <= '0;
        end else if (!power_on && pwr_nxt) begin
            tick_cnt <= '0;
            mileage  <= '0;
        end else if (state == ST_MOVE) begin
            if (tick_cnt == TICK_W'(MILE_TICK_CYCLES - 1)) begin
                tick_cnt <= '0;
                if (mileage != {MILE_W{1'b1}})
                    mileage <= mileage + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Scoreboard bench for manual_drive_ctrl: stimulus pushes expected output
// snapshots tagged with the cycle they are due; a negedge monitor pops and
// compares them against the packed DUT outputs.
module tb_manual_drive_ctrl;
    localparam int L = 8, B = 4, T = 5, MW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          power_btn, throttle, clutch, brake, reverse_sw, turn_left, turn_right;
    logic [1:0]    mode_sel;
    logic          power_on, mf, mb, tls, trs, tll, trl;
    logic [1:0]    drive_state;
    logic [MW-1:0] mileage;

    manual_drive_ctrl #(
        .LONG_PRESS_CYCLES(L), .BLINK_HALF_CYCLES(B),
        .MILE_TICK_CYCLES(T), .MILE_W(MW)
    ) dut (
        .clk(clk), .rst(rst), .power_btn(power_btn), .mode_sel(mode_sel),
        .throttle(throttle), .clutch(clutch), .brake(brake), .reverse_sw(reverse_sw),
        .turn_left(turn_left), .turn_right(turn_right),
        .power_on(power_on), .drive_state(drive_state),
        .move_forward_signal(mf), .move_backward_signal(mb),
        .turn_left_signal(tls), .turn_right_signal(trs),
        .turn_left_light(tll), .turn_right_light(trl),
        .mileage(mileage)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [32:0] exp;
        logic [32:0] mask;
    } sb_item_t;

    sb_item_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [32:0] M_ALL    = {33{1'b1}};
    localparam logic [32:0] M_NOMILE = {9'h1FF, 24'h0};

    logic [32:0] obs;
    assign obs = {power_on, drive_state, mf, mb, tls, trs, tll, trl, mileage};

    function automatic logic [32:0] E(input logic p, input logic [1:0] st,
                                      input logic f, input logic b,
                                      input logic l, input logic r,
                                      input logic ll, input logic rl,
                                      input int mile);
        return {p, st, f, b, l, r, ll, rl, MW'(mile)};
    endfunction

    task automatic put(input int dly, input string nm, input logic [32:0] e,
                       input logic [32:0] m);
        sb_item_t it;
        it.cyc = cyc + dly; it.name = nm; it.exp = e; it.mask = m;
        sb.push_back(it);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every item due this cycle; anything overdue is a miss.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            sb_item_t it;
            it = sb.pop_front();
            n_tests++;
            if (it.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d not taken (now %0d)", it.name, it.cyc, cyc);
            end else if (((obs ^ it.exp) & it.mask) != 33'h0) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%h expected=%h mask=%h",
                         it.name, cyc, obs, it.exp, it.mask);
            end
        end
    end

    task automatic power_pulse(input string nm);
        power_btn = 1'b1;
        put(3, nm, E(1, 2'b00, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        tick(1);
        power_btn = 1'b0;
        tick(4);
    endtask

    initial begin
        rst = 1'b1;
        {power_btn, throttle, clutch, brake, reverse_sw, turn_left, turn_right} = '0;
        mode_sel = 2'b01;
        #3 rst = 1'b0;
        tick(2);
        put(0, "reset_state", 33'h0, M_ALL);
        tick(1);
        rst = 1'b1;
        tick(1);

        power_pulse("power_on_pulse");

        // 7-cycle hold keeps power, 8-cycle hold drops it, continued hold stays off
        power_btn = 1'b1;
        put(3,  "hold7_mid",  E(1, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        put(10, "hold7_end",  E(1, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        tick(7);
        power_btn = 1'b0;
        tick(2);
        power_btn = 1'b1;
        put(9,  "hold8_pre",  E(1, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        put(10, "hold8_off",  33'h0, M_ALL);
        put(15, "held_off",   33'h0, M_ALL);
        tick(15);
        power_btn = 1'b0;
        put(5, "release_no_repower", 33'h0, M_ALL);
        tick(5);

        // stall from NOT_STARTING
        power_pulse("repower_1");
        throttle = 1'b1;
        put(3, "stall", 33'h0, M_ALL);
        tick(1);
        throttle = 1'b0;
        tick(4);
        power_pulse("repower_2");

        // STARTING, then left turn blinking
        throttle = 1'b1; clutch = 1'b1;
        put(3, "starting", E(1, 2'b01, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        tick(3);
        turn_left = 1'b1;
        put(2, "turn_latency", E(1, 2'b01, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        for (int i = 0; i < 12; i++)
            put(3 + i, $sformatf("blink_%0d", i),
                E(1, 2'b01, 0, 0, 1, 0, ((i % 8) < 4), 0, 0), M_ALL);
        tick(12);
        turn_right = 1'b1;
        put(3, "both_turn", E(1, 2'b01, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        tick(3);
        turn_left = 1'b0; turn_right = 1'b0;
        tick(1);

        // MOVING forward, mileage every 5 moving cycles
        clutch = 1'b0;
        put(3,  "moving_fwd", E(1, 2'b10, 1, 0, 0, 0, 0, 0, 0), M_ALL);
        put(7,  "mile_0",     E(1, 2'b10, 1, 0, 0, 0, 0, 0, 0), M_ALL);
        put(8,  "mile_1",     E(1, 2'b10, 1, 0, 0, 0, 0, 0, 1), M_ALL);
        put(13, "mile_2",     E(1, 2'b10, 1, 0, 0, 0, 0, 0, 2), M_ALL);
        put(18, "mile_3",     E(1, 2'b10, 1, 0, 0, 0, 0, 0, 3), M_ALL);
        tick(19);
        rst = 1'b0;
        put(0, "async_reset_moving", 33'h0, M_ALL);
        tick(2);
        throttle = 1'b0; clutch = 1'b0;
        rst = 1'b1;
        tick(1);

        // reverse toggle without clutch: power off, mileage held
        power_pulse("power_after_reset");
        throttle = 1'b1; clutch = 1'b1;
        put(3, "f_starting", E(1, 2'b01, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        tick(3);
        clutch = 1'b0;
        put(3, "f_moving", E(1, 2'b10, 1, 0, 0, 0, 0, 0, 0), M_ALL);
        put(8, "f_mile_1", E(1, 2'b10, 1, 0, 0, 0, 0, 0, 1), M_ALL);
        tick(9);
        reverse_sw = 1'b1;
        put(3, "rev_stall_hold_mile", E(0, 2'b00, 0, 0, 0, 0, 0, 0, 1), M_ALL);
        tick(3);
        throttle = 1'b0;
        tick(3);
        power_pulse("repower_clears_mile");

        // reverse gear, clutch-held toggle, mode idle, brake
        throttle = 1'b1; clutch = 1'b1;
        put(3, "g_starting", E(1, 2'b01, 0, 0, 0, 0, 0, 0, 0), M_NOMILE);
        tick(4);
        clutch = 1'b0;
        put(3, "g_backward", E(1, 2'b10, 0, 1, 0, 0, 0, 0, 0), M_NOMILE);
        tick(4);
        clutch = 1'b1; reverse_sw = 1'b0;
        put(3, "rev_with_clutch", E(1, 2'b01, 0, 0, 0, 0, 0, 0, 0), M_NOMILE);
        tick(4);
        clutch = 1'b0;
        put(3, "g_forward", E(1, 2'b10, 1, 0, 0, 0, 0, 0, 0), M_NOMILE);
        tick(4);
        mode_sel = 2'b10;
        put(3, "mode_idle", E(1, 2'b00, 0, 0, 0, 0, 0, 0, 0), M_NOMILE);
        tick(4);
        mode_sel = 2'b01; clutch = 1'b1;
        put(3, "mode_back_start", E(1, 2'b01, 0, 0, 0, 0, 0, 0, 0), M_NOMILE);
        tick(4);
        brake = 1'b1;
        put(3, "brake_idle", E(1, 2'b00, 0, 0, 0, 0, 0, 0, 0), M_NOMILE);
        tick(6);

        while (sb.size() > 0) begin
            sb_item_t it;
            it = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: check for cycle %0d never reached", it.name, it.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
